// File: rtl/pcm_out_fifo.sv
// Output FIFO for decimated PCM samples from the comb stage.
// Flushes on rate change, drops CIC settling samples, and tracks overflow drops.
module pcm_out_fifo #(
  parameter int DW     = 16,
  parameter int DEPTH  = 8,
  parameter int SETTLE = 5
) (
  input  logic                     clk_div,
  input  logic                     reset_n,
  input  logic [2:0]               os_sel,
  input  logic [DW-1:0]            data_in,
  output logic [DW-1:0]            out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic [7:0]               drop_cnt,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  logic [1:0]    r_state;
  logic [2:0]    r_os_sel_q;
  logic [CW-1:0] r_settle_cnt;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_ovf;
  logic [7:0]    r_drop_cnt;
  logic [DW-1:0] r_mem [DEPTH];

  logic          w_flush;
  logic          w_full;
  logic          w_empty;
  logic          w_rd;
  logic          w_wr_try;
  logic          w_wr;
  logic          w_drop;
  logic [1:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;

  // A disable or any rate change restarts the pipeline from an empty FIFO.
  assign w_flush  = (os_sel == 3'd0) || (os_sel != r_os_sel_q);
  assign w_full   = (r_level == LW'(DEPTH));
  assign w_empty  = (r_level == '0);
  assign w_rd     = !w_empty && out_ready && !w_flush;
  assign w_wr_try = (r_state == ST_RUN) && !w_flush;
  assign w_wr     = w_wr_try && (!w_full || w_rd);
  assign w_drop   = w_wr_try && w_full && !w_rd;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_settle_cnt;
    if (os_sel == 3'd0) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else if (os_sel != r_os_sel_q) begin
      w_state_nxt = ST_SETTLE;
      w_cnt_nxt   = '0;
    end else if (r_state == ST_SETTLE) begin
      w_cnt_nxt = r_settle_cnt + 1'b1;
      if (r_settle_cnt == CW'(SETTLE - 1)) begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_os_sel_q   <= 3'd0;
      r_settle_cnt <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_os_sel_q   <= os_sel;
      r_settle_cnt <= w_cnt_nxt;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_wr, w_rd})
          2'b10:   r_level <= r_level + 1'b1;
          2'b01:   r_level <= r_level - 1'b1;
          default: r_level <= r_level;
        endcase
      end
    end
  end

  // Overflow bookkeeping survives flushes; a drop coincident with a clear is still counted.
  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else if (ovf_clr) begin
      r_ovf      <= w_drop;
      r_drop_cnt <= {7'd0, w_drop};
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  // NOTE: storage is not reset; the empty-forces-zero output mux hides stale entries.
  always_ff @(posedge clk_div) begin
    if (w_wr) r_mem[r_wr_ptr] <= data_in;
  end

  assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign out_valid = !w_empty;
  assign level     = r_level;
  assign ovf       = r_ovf;
  assign drop_cnt  = r_drop_cnt;

endmodule
